// File: rtl/ulpi_reg_read_seq.sv
// ULPI register-read sequencer: accepts one read at a time, waits for an idle bus, drives
// the read engine and returns a response. `define ULPI_REG_READ_SEQ_RETRY_EN retries once after a timeout.
//
// state     | meaning
// IDLE      | ready for a request
// WAIT_BUS  | counting consecutive DIR-low cycles
// LAUNCH    | RD_START pulse, timeout counter cleared
// WAIT_ACK  | waiting for engine to raise RD_BUSY
// WAIT_DONE | waiting for engine to drop RD_BUSY
// ABORT     | RD_ABORT pulse, count error, respond or retry
module ulpi_reg_read_seq #(
    parameter int unsigned BUS_IDLE_CYC = 2,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [5:0] REQ_ADDR,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       RSP_TIMEOUT,
    output logic [7:0] ERR_CNT,
    input  logic       DIR,
    output logic       RD_START,
    output logic [5:0] RD_ADDR,
    input  logic       RD_BUSY,
    input  logic [7:0] RD_DATA,
    output logic       RD_ABORT
);

    localparam int unsigned IDLE_W = $clog2(BUS_IDLE_CYC + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(BUS_IDLE_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        LAUNCH,
        WAIT_ACK,
        WAIT_DONE,
        ABORT
    } state_t;

    state_t            state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [5:0]        rd_addr_q, rd_addr_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
    logic              retry_q, retry_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idle_q        <= '0;
            tmo_q         <= '0;
            rd_addr_q     <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_cnt_q     <= '0;
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
            retry_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idle_q        <= idle_d;
            tmo_q         <= tmo_d;
            rd_addr_q     <= rd_addr_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_cnt_q     <= err_cnt_d;
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
            retry_q       <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        idle_d        = idle_q;
        tmo_d         = tmo_q;
        rd_addr_d     = rd_addr_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        err_cnt_d     = err_cnt_q;
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
        retry_d       = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    rd_addr_d = REQ_ADDR;
                    idle_d    = '0;
                    state_d   = WAIT_BUS;
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            WAIT_BUS: begin
                if (DIR) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q == IDLE_LAST) state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (RD_BUSY)                state_d = WAIT_DONE;
                else if (tmo_q == TMO_LAST) state_d = ABORT;
            end
            WAIT_DONE: begin
                tmo_d = tmo_q + TMO_W'(1);
                // completion is checked first so it wins a tie with the timeout
                if (!RD_BUSY) begin
                    rsp_data_d  = RD_DATA;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                idle_d    = '0;
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
                if (!retry_q) begin
                    retry_d = 1'b1;
                    state_d = WAIT_BUS;
                end else begin
                    rsp_data_d    = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
`else
                rsp_data_d    = '0;
                rsp_valid_d   = 1'b1;
                rsp_timeout_d = 1'b1;
                state_d       = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign REQ_READY   = (state_q == IDLE);
    assign RD_START    = (state_q == LAUNCH);
    assign RD_ABORT    = (state_q == ABORT);
    assign RD_ADDR     = rd_addr_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign RSP_DATA    = rsp_data_q;
    assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_ulpi_reg_read_seq.sv
// Directed bench for ulpi_reg_read_seq. Cycle numbers are counted from the accept cycle (0);
// inputs are driven and outputs sampled on the falling edge.
module tb_ulpi_reg_read_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [5:0] REQ_ADDR = '0;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       RSP_TIMEOUT;
    logic [7:0] ERR_CNT;
    logic       DIR = 1'b0;
    logic       RD_START;
    logic [5:0] RD_ADDR;
    logic       RD_BUSY = 1'b0;
    logic [7:0] RD_DATA = '0;
    logic       RD_ABORT;

    int errors = 0;
    int checks = 0;

    ulpi_reg_read_seq #(.BUS_IDLE_CYC(2), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_TIMEOUT(RSP_TIMEOUT),
        .ERR_CNT(ERR_CNT), .DIR(DIR),
        .RD_START(RD_START), .RD_ADDR(RD_ADDR), .RD_BUSY(RD_BUSY),
        .RD_DATA(RD_DATA), .RD_ABORT(RD_ABORT)
    );

    always #5 clk = ~clk;

    // measurements of the last transaction run by do_read
    int         m_start_cyc, m_nstart, m_abort_cyc, m_nabort, m_rsp_cyc, m_nrsp;
    logic       m_ready0, m_ready_after, m_rsp_to, m_hung;
    logic [7:0] m_rsp_data;
    logic [5:0] m_addr_at_start;

    // One request plus an engine model. len<0 means the engine never drops busy.
    // While the request is outstanding REQ_VALID stays high with a different address.
    task automatic do_read(input logic [5:0] addr, input logic [31:0] dir_vec,
                           input int len1, input int len2, input logic [7:0] data);
        int rsp_at = -1;
        int attempt = 0;
        int busy_from = 1 << 30;
        int busy_end = -1;
        int len;
        m_start_cyc = -1; m_nstart = 0; m_abort_cyc = -1; m_nabort = 0;
        m_rsp_cyc = -1; m_nrsp = 0; m_rsp_data = 'x; m_rsp_to = 1'bx;
        m_ready0 = 1'b0; m_ready_after = 1'b0; m_addr_at_start = 'x; m_hung = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0) m_ready0 = REQ_READY;
            if (RD_START) begin
                attempt++;
                m_nstart++;
                if (m_nstart == 1) begin m_start_cyc = c; m_addr_at_start = RD_ADDR; end
                len = (attempt == 1) ? len1 : len2;
                busy_from = c + 1;
                busy_end = (len < 0) ? (1 << 30) : c + len;
            end
            if (RD_ABORT) begin
                m_nabort++;
                if (m_nabort == 1) m_abort_cyc = c;
                busy_end = c - 1;
            end
            if (RSP_VALID) begin
                m_nrsp++;
                if (rsp_at < 0) begin
                    rsp_at = c; m_rsp_cyc = c; m_rsp_data = RSP_DATA;
                    m_rsp_to = RSP_TIMEOUT; m_ready_after = REQ_READY;
                end
            end
            if (rsp_at >= 0 && c == rsp_at + 2) begin
                m_hung = 1'b0;
                break;
            end
            REQ_VALID = (rsp_at < 0);
            REQ_ADDR  = (c == 0) ? addr : ~addr;
            DIR       = (c < 32) ? dir_vec[c] : 1'b0;
            RD_BUSY   = (c >= busy_from && c <= busy_end);
            RD_DATA   = RD_BUSY ? ~data : data;
        end
        REQ_VALID = 1'b0; DIR = 1'b0; RD_BUSY = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset REQ_READY got %b want 1", REQ_READY); end
        checks++; if ({RSP_VALID, RSP_TIMEOUT, RD_START, RD_ABORT} !== 4'b0000) begin errors++; $display("FAIL reset pulses got %b want 0000", {RSP_VALID, RSP_TIMEOUT, RD_START, RD_ABORT}); end
        checks++; if ({RSP_DATA, RD_ADDR, ERR_CNT} !== 22'd0) begin errors++; $display("FAIL reset data/addr/err got %h/%h/%h want 0", RSP_DATA, RD_ADDR, ERR_CNT); end
    endtask

    task automatic test_nominal();
        do_read(6'h16, 32'h0, 5, 5, 8'hA5);
        checks++; if (m_hung !== 1'b0) begin errors++; $display("FAIL nominal no response within budget"); end
        checks++; if (m_ready0 !== 1'b1) begin errors++; $display("FAIL nominal ready_at_accept got %b want 1", m_ready0); end
        checks++; if (m_start_cyc !== 3) begin errors++; $display("FAIL nominal start_cycle got %0d want 3", m_start_cyc); end
        checks++; if (m_nstart !== 1) begin errors++; $display("FAIL nominal start_pulses got %0d want 1", m_nstart); end
        checks++; if (m_addr_at_start !== 6'h16) begin errors++; $display("FAIL nominal rd_addr got %h want 16", m_addr_at_start); end
        checks++; if (m_rsp_cyc !== 10) begin errors++; $display("FAIL nominal rsp_cycle got %0d want 10", m_rsp_cyc); end
        checks++; if (m_nrsp !== 1) begin errors++; $display("FAIL nominal rsp_pulses got %0d want 1", m_nrsp); end
        checks++; if (m_rsp_data !== 8'hA5) begin errors++; $display("FAIL nominal rsp_data got %h want a5", m_rsp_data); end
        checks++; if (m_rsp_to !== 1'b0) begin errors++; $display("FAIL nominal rsp_timeout got %b want 0", m_rsp_to); end
        checks++; if (m_ready_after !== 1'b1) begin errors++; $display("FAIL nominal ready_after got %b want 1", m_ready_after); end
        checks++; if (m_nabort !== 0) begin errors++; $display("FAIL nominal abort_pulses got %0d want 0", m_nabort); end
        checks++; if (RD_ADDR !== 6'h16) begin errors++; $display("FAIL nominal rd_addr_held got %h want 16", RD_ADDR); end
    endtask

    task automatic test_bus_busy();
        // DIR high cycles 1..10 except a low glitch at cycle 4
        do_read(6'h2B, 32'h0000_07EE, 2, 2, 8'h5C);
        checks++; if (m_start_cyc !== 13) begin errors++; $display("FAIL bus_busy start_cycle got %0d want 13", m_start_cyc); end
        checks++; if (m_nstart !== 1) begin errors++; $display("FAIL bus_busy start_pulses got %0d want 1", m_nstart); end
        checks++; if (m_rsp_cyc !== 17 || m_rsp_data !== 8'h5C) begin errors++; $display("FAIL bus_busy rsp got cyc %0d data %h want 17 5c", m_rsp_cyc, m_rsp_data); end
        checks++; if (m_addr_at_start !== 6'h2B) begin errors++; $display("FAIL bus_busy rd_addr got %h want 2b", m_addr_at_start); end
    endtask

    task automatic test_race();
        // busy drops in the cycle where the timeout counter is at its last value
        do_read(6'h05, 32'h0, 63, 63, 8'hC3);
        checks++; if (m_nabort !== 0) begin errors++; $display("FAIL race abort_pulses got %0d want 0", m_nabort); end
        checks++; if (m_rsp_cyc !== 68 || m_rsp_to !== 1'b0 || m_rsp_data !== 8'hC3) begin errors++; $display("FAIL race rsp got cyc %0d to %b data %h want 68 0 c3", m_rsp_cyc, m_rsp_to, m_rsp_data); end
        checks++; if (ERR_CNT !== 8'd0) begin errors++; $display("FAIL race err_cnt got %0d want 0", ERR_CNT); end
    endtask

`ifndef ULPI_REG_READ_SEQ_RETRY_EN
    task automatic test_hung_phy();
        do_read(6'h3E, 32'h0, -1, -1, 8'h99);
        checks++; if (m_abort_cyc !== 68 || m_nabort !== 1) begin errors++; $display("FAIL hung abort got cyc %0d n %0d want 68 1", m_abort_cyc, m_nabort); end
        checks++; if (m_rsp_cyc !== 69 || m_rsp_to !== 1'b1 || m_rsp_data !== 8'h00) begin errors++; $display("FAIL hung rsp got cyc %0d to %b data %h want 69 1 00", m_rsp_cyc, m_rsp_to, m_rsp_data); end
        checks++; if (ERR_CNT !== 8'd1) begin errors++; $display("FAIL hung err_cnt got %0d want 1", ERR_CNT); end
        // busy drops one cycle too late: timeout wins
        do_read(6'h3D, 32'h0, 64, 64, 8'h11);
        checks++; if (m_abort_cyc !== 68 || m_rsp_to !== 1'b1 || m_nrsp !== 1) begin errors++; $display("FAIL late_done got abort %0d to %b nrsp %0d want 68 1 1", m_abort_cyc, m_rsp_to, m_nrsp); end
        checks++; if (ERR_CNT !== 8'd2) begin errors++; $display("FAIL late_done err_cnt got %0d want 2", ERR_CNT); end
    endtask
`else
    task automatic test_retry();
        do_read(6'h12, 32'h0, -1, 5, 8'h3C);
        checks++; if (m_nabort !== 1 || m_abort_cyc !== 68) begin errors++; $display("FAIL retry abort got n %0d cyc %0d want 1 68", m_nabort, m_abort_cyc); end
        checks++; if (m_nstart !== 2) begin errors++; $display("FAIL retry start_pulses got %0d want 2", m_nstart); end
        checks++; if (m_nrsp !== 1 || m_rsp_cyc !== 78) begin errors++; $display("FAIL retry rsp got n %0d cyc %0d want 1 78", m_nrsp, m_rsp_cyc); end
        checks++; if (m_rsp_data !== 8'h3C || m_rsp_to !== 1'b0) begin errors++; $display("FAIL retry rsp got data %h to %b want 3c 0", m_rsp_data, m_rsp_to); end
        checks++; if (ERR_CNT !== 8'd1) begin errors++; $display("FAIL retry err_cnt got %0d want 1", ERR_CNT); end
        checks++; if (RD_ADDR !== 6'h12) begin errors++; $display("FAIL retry rd_addr got %h want 12", RD_ADDR); end
        do_read(6'h13, 32'h0, -1, -1, 8'h44);
        checks++; if (m_nabort !== 2 || m_rsp_cyc !== 137) begin errors++; $display("FAIL retry2 got aborts %0d rsp_cyc %0d want 2 137", m_nabort, m_rsp_cyc); end
        checks++; if (m_rsp_to !== 1'b1 || m_rsp_data !== 8'h00 || m_nrsp !== 1) begin errors++; $display("FAIL retry2 rsp got to %b data %h n %0d want 1 00 1", m_rsp_to, m_rsp_data, m_nrsp); end
        checks++; if (ERR_CNT !== 8'd3) begin errors++; $display("FAIL retry2 err_cnt got %0d want 3", ERR_CNT); end
    endtask
`endif

    task automatic test_reset_mid();
        logic found = 1'b0;
        @(negedge clk);
        REQ_VALID = 1'b1; REQ_ADDR = 6'h21;
        @(negedge clk);
        REQ_VALID = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (RD_START) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL reset_mid no RD_START within 20 cycles"); end
        RD_BUSY = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (REQ_READY !== 1'b0 || RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_mid busy got ready %b rsp %b want 0 0", REQ_READY, RSP_VALID); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; RD_BUSY = 1'b0;
        checks++; if (REQ_READY !== 1'b1 || {RSP_VALID, RSP_TIMEOUT, RD_START, RD_ABORT} !== 4'b0000) begin errors++; $display("FAIL reset_mid pulses got ready %b %b want 1 0000", REQ_READY, {RSP_VALID, RSP_TIMEOUT, RD_START, RD_ABORT}); end
        checks++; if ({RSP_DATA, RD_ADDR, ERR_CNT} !== 22'd0) begin errors++; $display("FAIL reset_mid data/addr/err got %h/%h/%h want 0", RSP_DATA, RD_ADDR, ERR_CNT); end
        @(negedge clk);
        checks++; if (RSP_VALID !== 1'b0 || RD_ABORT !== 1'b0) begin errors++; $display("FAIL reset_mid after got rsp %b abort %b want 0 0", RSP_VALID, RD_ABORT); end
        do_read(6'h0A, 32'h0, 3, 3, 8'h77);
        checks++; if (m_start_cyc !== 3 || m_addr_at_start !== 6'h0A) begin errors++; $display("FAIL post_reset start got cyc %0d addr %h want 3 0a", m_start_cyc, m_addr_at_start); end
        checks++; if (m_rsp_cyc !== 8 || m_rsp_data !== 8'h77 || m_rsp_to !== 1'b0) begin errors++; $display("FAIL post_reset rsp got cyc %0d data %h to %b want 8 77 0", m_rsp_cyc, m_rsp_data, m_rsp_to); end
    endtask

    task automatic test_err_saturate();
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
        int n = 128;
`else
        int n = 256;
`endif
        int hung = 0;
        for (int i = 0; i < n; i++) begin
            do_read(6'(i), 32'h0, -1, -1, 8'h00);
            if (m_hung) hung++;
        end
        checks++; if (hung !== 0) begin errors++; $display("FAIL saturate hung_reads got %0d want 0", hung); end
        checks++; if (ERR_CNT !== 8'd255) begin errors++; $display("FAIL saturate err_cnt got %0d want 255", ERR_CNT); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bus_busy();
        test_race();
`ifdef ULPI_REG_READ_SEQ_RETRY_EN
        test_retry();
`else
        test_hung_phy();
`endif
        test_reset_mid();
        test_err_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
